// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS datapath immediate-generation stage.
//   imm_mode_e : immediate extension modes carried on in_mode
//   occ_e      : occupancy of the two-entry output/skid buffer
//   MODE_W     : width of the mode select
package cpu_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    IMM_SIGN   = 2'd0,
    IMM_ZERO   = 2'd1,
    IMM_UPPER  = 2'd2,
    IMM_BRANCH = 2'd3
  } imm_mode_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_extend_comb.sv
// Purely combinational immediate extension.
//   in_imm  [IN_W]   raw immediate
//   in_mode [MODE_W] SIGN / ZERO / UPPER / BRANCH
//   result  [OUT_W]  extended operand
// Build option IMM_EXTEND_BRANCH_EN: when defined, mode 3 sign-extends and
// shifts left by BR_SHIFT; when undefined, mode 3 is identical to SIGN and
// no shifter exists.
module imm_extend_comb
  import cpu_pkg::*;
#(
  parameter int IN_W     = 16,
`ifdef IMM_EXTEND_BRANCH_EN
  parameter int BR_SHIFT = 2,
`endif
  parameter int OUT_W    = 32
) (
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  output logic [OUT_W-1:0]  result
);

  logic signed [IN_W-1:0]  imm_s;
  logic signed [OUT_W-1:0] sext;
  logic        [OUT_W-1:0] zext;
  logic        [OUT_W-1:0] upper;

  assign imm_s = signed'(in_imm);
  // Size cast of a signed operand replicates the sign bit; this also
  // degenerates cleanly when OUT_W == IN_W.
  assign sext  = OUT_W'(imm_s);
  assign zext  = OUT_W'(in_imm);
  assign upper = zext << (OUT_W - IN_W);

  always_comb begin
    result = sext;
    case (imm_mode_e'(in_mode))
      IMM_SIGN:   result = sext;
      IMM_ZERO:   result = zext;
      IMM_UPPER:  result = upper;
`ifdef IMM_EXTEND_BRANCH_EN
      IMM_BRANCH: result = sext <<< BR_SHIFT;
`else
      IMM_BRANCH: result = sext;
`endif
      default:    result = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-generation stage at the ID/EX boundary.
// Extension is done combinationally on the input; only extended results are
// stored, in an output register plus one skid register (2-entry FIFO).
//   clk, reset      clock, synchronous active-high reset
//   flush           drop everything held; an input firing this cycle is lost
//   in_valid/ready  upstream handshake (in_ready is a flop, !TWO)
//   in_imm, in_mode raw immediate and extension mode
//   out_valid/ready downstream handshake (out_valid is a flop)
//   out_imm         extended operand, out_neg its MSB
// Build option IMM_EXTEND_BRANCH_EN enables the branch-offset shift for mode 3.
module imm_extend_pipe
  import cpu_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_imm,
  output logic              out_neg
);

  if ((OUT_W < IN_W) || (OUT_W < IN_W + BR_SHIFT)) begin : g_width_check
    $error("imm_extend_pipe: OUT_W too narrow for IN_W/BR_SHIFT");
  end

  logic signed [OUT_W-1:0] ext_p0;
  logic signed [OUT_W-1:0] out_data_p1;
  logic signed [OUT_W-1:0] skid_data_p1;
  occ_e state_q, state_d;
  logic rdy_q, vld_q;
  logic load_out, load_skid, move_skid;
  logic in_fire, out_fire;

  // Stage p0: combinational extension of the incoming immediate
  imm_extend_comb #(
    .IN_W     (IN_W),
`ifdef IMM_EXTEND_BRANCH_EN
    .BR_SHIFT (BR_SHIFT),
`endif
    .OUT_W    (OUT_W)
  ) u_ext (
    .in_imm  (in_imm),
    .in_mode (in_mode),
    .result  (ext_p0)
  );

  assign in_fire  = in_valid & rdy_q;
  assign out_fire = vld_q & out_ready;

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            state_d  = OCC_ONE;
            load_out = 1'b1;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            load_out = 1'b1;
          end else if (in_fire) begin
            state_d   = OCC_TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // in_ready is low here, so only the drain case exists.
          if (out_fire) begin
            state_d   = OCC_ONE;
            move_skid = 1'b1;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  // Stage p1: output and skid registers with occupancy state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= OCC_EMPTY;
      rdy_q        <= 1'b1;
      vld_q        <= 1'b0;
      out_data_p1  <= '0;
      skid_data_p1 <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != OCC_TWO);
      vld_q   <= (state_d != OCC_EMPTY);
      if (load_out) begin
        out_data_p1 <= ext_p0;
      end else if (move_skid) begin
        out_data_p1 <= skid_data_p1;
      end
      if (load_skid) begin
        skid_data_p1 <= ext_p0;
      end
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_imm   = out_data_p1;
  assign out_neg   = out_data_p1[OUT_W-1];

endmodule
